// File: rtl/img_capture_stats.sv
// Image sensor capture engine: arms on command, skips a programmable number of
// frames, streams one frame as 16-bit words and gathers sparse-grid statistics.
module img_capture_stats #(
  parameter int  PixelWidth    = 12,
  parameter int  SkipWidth     = 2,
  parameter int  StatWidth     = 18,
  parameter int  StrideLog2    = 2,
  parameter int  ThreshBits    = 7,
  parameter int  ImgPixelCount = 4096 * 4096,
  localparam int CountWidth    = $clog2(ImgPixelCount + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_capture,
  input  logic                  cmd_abort,
  input  logic [SkipWidth-1:0]  cmd_skipCount,
  input  logic [PixelWidth-1:0] img_d,
  input  logic                  img_fv,
  input  logic                  img_lv,
  input  logic                  w_ready,
  output logic                  w_trigger,
  output logic [15:0]           w_data,
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_overflow,
  output logic [CountWidth-1:0] status_pixelCount,
  output logic [StatWidth-1:0]  status_highlightCount,
  output logic [StatWidth-1:0]  status_shadowCount
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_WAIT_FRAME, ST_SKIP, ST_CAPTURE
  } state_t;

  state_t                state_q, state_d;
  logic [SkipWidth-1:0]  skip_q, skip_d;
  logic [PixelWidth-1:0] s1_px_q, s1_px_d;
  logic                  s1_fv_q, s1_fv_d;
  logic                  s1_lv_q, s1_lv_d;
  logic                  fv_prev_q, fv_prev_d;
  logic                  lv_prev_q, lv_prev_d;
  logic [StrideLog2-1:0] x_q, x_d;
  logic [StrideLog2-1:0] y_q, y_d;
  logic                  trig_q, trig_d;
  logic [15:0]           data_q, data_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [StatWidth-1:0]  hi_q, hi_d;
  logic [StatWidth-1:0]  sh_q, sh_d;
  logic                  samp_vld_q, samp_vld_d;
  logic [ThreshBits-1:0] samp_top_q, samp_top_d;
  logic                  emit;
  logic [15:0]           word_fmt;

  // Low byte of the pixel goes in the upper byte of the word.
  if (PixelWidth > 8) begin : g_wide
    assign word_fmt = {s1_px_q[7:0], 8'(s1_px_q[PixelWidth-1:8])};
  end else begin : g_narrow
    assign word_fmt = {8'(s1_px_q), 8'h00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      s1_px_q    <= '0;
      s1_fv_q    <= 1'b0;
      s1_lv_q    <= 1'b0;
      fv_prev_q  <= 1'b0;
      lv_prev_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      trig_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      sh_q       <= '0;
      samp_vld_q <= 1'b0;
      samp_top_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      s1_px_q    <= s1_px_d;
      s1_fv_q    <= s1_fv_d;
      s1_lv_q    <= s1_lv_d;
      fv_prev_q  <= fv_prev_d;
      lv_prev_q  <= lv_prev_d;
      x_q        <= x_d;
      y_q        <= y_d;
      trig_q     <= trig_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      sh_q       <= sh_d;
      samp_vld_q <= samp_vld_d;
      samp_top_q <= samp_top_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    s1_px_d   = img_d;
    s1_fv_d   = img_fv;
    s1_lv_d   = img_lv;
    fv_prev_d = s1_fv_q;
    lv_prev_d = s1_lv_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    sh_d      = sh_q;

    x_d = s1_lv_q ? x_q + 1'b1 : '0;
    y_d = !s1_fv_q ? '0 : ((lv_prev_q && !s1_lv_q) ? y_q + 1'b1 : y_q);

    // A pending command suppresses the word so nothing leaks out after abort/re-arm.
    emit       = (state_q == ST_CAPTURE) && s1_fv_q && s1_lv_q && !cmd_capture && !cmd_abort;
    trig_d     = emit;
    data_d     = emit ? word_fmt : data_q;
    samp_vld_d = emit && (x_q == '0) && (y_q == '0);
    samp_top_d = samp_vld_d ? s1_px_q[PixelWidth-1 -: ThreshBits] : samp_top_q;

    if (trig_q) begin
      if (w_ready) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (samp_vld_q) begin
      if (&samp_top_q) begin
        if (hi_q != '1) hi_d = hi_q + 1'b1;
      end else if (~|samp_top_q) begin
        if (sh_q != '1) sh_d = sh_q + 1'b1;
      end
    end

    case (state_q)
      ST_ARM: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        hi_d    = '0;
        sh_d    = '0;
        state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (s1_fv_q && !fv_prev_q) state_d = ST_SKIP;
      end
      ST_SKIP: begin
        if (skip_q != '0) begin
          skip_d  = skip_q - 1'b1;
          state_d = ST_WAIT_FRAME;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!s1_fv_q) begin
          state_d = ST_IDLE;
          done_d  = ~done_q;
        end
      end
      default: ;
    endcase

    if (cmd_abort) begin
      state_d = ST_IDLE;
      done_d  = done_q;
    end
    if (cmd_capture) begin
      state_d = ST_ARM;
      skip_d  = cmd_skipCount;
      done_d  = done_q;
    end
  end

  assign w_trigger             = trig_q;
  assign w_data                = data_q;
  assign status_busy           = (state_q != ST_IDLE);
  assign status_done           = done_q;
  assign status_overflow       = ovf_q;
  assign status_pixelCount     = cnt_q;
  assign status_highlightCount = hi_q;
  assign status_shadowCount    = sh_q;
endmodule

// File: tb/tb_img_capture_stats.sv
// Bench for img_capture_stats: directed table of capture scenarios, abort/reset
// sequences and randomized captures checked cycle by cycle against a frame model.
module tb_img_capture_stats;
  logic        clk = 1'b0;
  logic        rst, cmd_capture, cmd_abort, img_fv, img_lv, w_ready;
  logic [1:0]  cmd_skipCount;
  logic [11:0] img_d;
  logic        w_trigger;
  logic [15:0] w_data;
  logic        status_busy, status_done, status_overflow;
  logic [24:0] status_pixelCount;
  logic [17:0] status_highlightCount, status_shadowCount;

  int   errors = 0;
  int   checks = 0;
  int   exp_cnt, exp_hi, exp_sh;
  logic exp_ovf;
  logic exp_done = 1'b0;

  typedef struct {
    logic        fv;
    logic        lv;
    logic [11:0] d;
    int          k;
    int          x;
    int          y;
  } cyc_t;

  typedef struct {
    int skip; int w; int h; int nfr; int pmode; int rmode;
    int exp_words; int exp_cnt; int exp_hi; int exp_sh; int exp_ovf; int exp_first;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  img_capture_stats dut (
    .clk(clk), .rst(rst), .cmd_capture(cmd_capture), .cmd_abort(cmd_abort),
    .cmd_skipCount(cmd_skipCount), .img_d(img_d), .img_fv(img_fv), .img_lv(img_lv),
    .w_ready(w_ready), .w_trigger(w_trigger), .w_data(w_data),
    .status_busy(status_busy), .status_done(status_done),
    .status_overflow(status_overflow), .status_pixelCount(status_pixelCount),
    .status_highlightCount(status_highlightCount), .status_shadowCount(status_shadowCount)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int pmode, input int f, input int x, input int y);
    logic [11:0] v;
    int c;
    case (pmode)
      0: v = 12'(f + 1);
      1: begin
        if (y == 0 && (x == 0 || x == 4)) v = 12'hFFF;
        else if (x == 0 && y == 4) v = 12'h000;
        else v = 12'h800;
      end
      default: begin
        c = $urandom_range(0, 3);
        if (c == 0) v = 12'(4064 + $urandom_range(0, 31));
        else if (c == 1) v = 12'($urandom_range(0, 31));
        else v = 12'($urandom_range(0, 4095));
      end
    endcase
    return v;
  endfunction

  // Pixel p becomes word (p mod 256)*256 + (p div 256).
  function automatic int fmt(input logic [11:0] px);
    int p;
    p = px;
    return (p % 256) * 256 + p / 256;
  endfunction

  task automatic push_idle(inout cyc_t st[$], input logic fv);
    cyc_t c;
    c = '{fv, 1'b0, 12'h000, -1, 0, 0};
    st.push_back(c);
  endtask

  task automatic run_capture(input int skip, input int w, input int h, input int nfr,
                             input int pmode, input int rmode, input int cut_k,
                             input int cut_kind, output int n_words, output int first_word);
    cyc_t st[$];
    cyc_t c;
    int   exp_k[$];
    logic rdy_a[$];
    int   cut_j;
    int   k;
    int   len;
    cut_j      = -1;
    n_words    = 0;
    first_word = -1;
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 3; i++) push_idle(st, 1'b1);
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          c = '{1'b1, 1'b1, pix(pmode, f, x, y), (f == skip) ? y * w + x : -1, x, y};
          st.push_back(c);
        end
        push_idle(st, 1'b1);
        if (y != h - 1) push_idle(st, 1'b1);
      end
      for (int i = 0; i < 3; i++) push_idle(st, 1'b0);
    end
    len = st.size();
    for (int j = 0; j < len + 2; j++) begin
      k = (j >= 2) ? st[j-2].k : -1;
      if (cut_j >= 0 && j > cut_j) k = -1;
      if (cut_kind != 0 && k == cut_k) cut_j = j;
      exp_k.push_back(k);
      if (rmode == 2) rdy_a.push_back($urandom_range(0, 3) != 0);
      else rdy_a.push_back(!(rmode == 1 && (k inside {2, 5, 6, 9, 13})));
    end

    cmd_capture   = 1'b1;
    cmd_skipCount = 2'(skip);
    @(negedge clk);
    cmd_capture = 1'b0;
    exp_cnt = 0; exp_hi = 0; exp_sh = 0; exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("arm_clear_count", status_pixelCount, 0);
    check("arm_clear_ovf", status_overflow, 0);
    check("arm_busy", status_busy, 1);

    for (int j = 0; j < len + 2; j++) begin
      k = exp_k[j];
      check("w_trigger", w_trigger, k >= 0);
      if (w_trigger) begin
        n_words++;
        if (first_word < 0) first_word = w_data;
      end
      if (k >= 0) begin
        check("w_data", w_data, fmt(st[j-2].d));
        if (rdy_a[j]) exp_cnt++;
        else exp_ovf = 1'b1;
        if (st[j-2].x % 4 == 0 && st[j-2].y % 4 == 0) begin
          if (st[j-2].d / 32 == 127) exp_hi++;
          else if (st[j-2].d / 32 == 0) exp_sh++;
        end
      end
      if (cut_j >= 0 && j == cut_j + 1) begin
        check("cut_busy", status_busy, 0);
        if (cut_kind == 2) begin
          check("rst_count", status_pixelCount, 0);
          check("rst_data", w_data, 0);
          check("rst_done", status_done, 0);
          check("rst_ovf", status_overflow, 0);
          check("rst_hi", status_highlightCount, 0);
        end else begin
          check("abort_done", status_done, exp_done);
        end
      end
      w_ready = rdy_a[j];
      if (j < len) begin
        img_fv = st[j].fv; img_lv = st[j].lv; img_d = st[j].d;
      end else begin
        img_fv = 1'b0; img_lv = 1'b0; img_d = '0;
      end
      cmd_abort = (cut_kind == 1 && j == cut_j);
      rst       = (cut_kind == 2 && j == cut_j);
      @(negedge clk);
    end
    cmd_abort = 1'b0;
    rst       = 1'b0;

    if (cut_kind == 2) begin
      exp_cnt = 0; exp_hi = 0; exp_sh = 0; exp_ovf = 1'b0; exp_done = 1'b0;
    end else if (cut_kind == 0 && nfr > skip) begin
      exp_done = ~exp_done;
    end
    check("pixel_count", status_pixelCount, exp_cnt);
    check("highlight", status_highlightCount, exp_hi);
    check("shadow", status_shadowCount, exp_sh);
    check("overflow", status_overflow, exp_ovf);
    check("done", status_done, exp_done);
    check("busy_end", status_busy, 0);
    $display("capture skip=%0d size=%0dx%0d frames=%0d cut=%0d words=%0d count=%0d hi=%0d sh=%0d ovf=%0d done=%0d",
             skip, w, h, nfr, cut_kind, n_words, status_pixelCount, status_highlightCount,
             status_shadowCount, status_overflow, status_done);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, fw;
    vecs[0] = '{0, 4, 4, 1, 0, 0, 16, 16, 0, 1, 0, 'h0100};
    vecs[1] = '{2, 4, 4, 3, 0, 0, 16, 16, 0, 1, 0, 'h0300};
    vecs[2] = '{0, 8, 8, 1, 1, 0, 64, 64, 2, 1, 0, 'hFF0F};
    vecs[3] = '{0, 4, 4, 1, 0, 1, 16, 11, 0, 1, 1, 'h0100};

    rst = 1'b1; cmd_capture = 1'b0; cmd_abort = 1'b0; cmd_skipCount = '0;
    img_d = '0; img_fv = 1'b0; img_lv = 1'b0; w_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_trigger", w_trigger, 0);
    check("reset_data", w_data, 0);
    check("reset_busy", status_busy, 0);
    check("reset_done", status_done, 0);
    check("reset_ovf", status_overflow, 0);
    check("reset_count", status_pixelCount, 0);
    check("reset_hi", status_highlightCount, 0);
    check("reset_sh", status_shadowCount, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_capture(vecs[i].skip, vecs[i].w, vecs[i].h, vecs[i].nfr, vecs[i].pmode,
                  vecs[i].rmode, -1, 0, nw, fw);
      check("tbl_words", nw, vecs[i].exp_words);
      check("tbl_first_word", fw, vecs[i].exp_first);
      check("tbl_count", status_pixelCount, vecs[i].exp_cnt);
      check("tbl_hi", status_highlightCount, vecs[i].exp_hi);
      check("tbl_sh", status_shadowCount, vecs[i].exp_sh);
      check("tbl_ovf", status_overflow, vecs[i].exp_ovf);
    end

    repeat (5) @(negedge clk);
    check("ovf_hold", status_overflow, 1);
    check("count_hold", status_pixelCount, 11);

    run_capture(0, 6, 4, 1, 2, 2, 9, 1, nw, fw);
    check("abort_words", nw, 10);
    run_capture(1, 5, 5, 2, 2, 0, 7, 2, nw, fw);
    check("rst_words", nw, 8);
    run_capture(0, 4, 4, 1, 0, 0, -1, 0, nw, fw);
    check("post_rst_count", status_pixelCount, 16);

    for (int r = 0; r < 10; r++) begin
      int skip;
      skip = $urandom_range(0, 3);
      run_capture(skip, $urandom_range(1, 9), $urandom_range(1, 9),
                  skip + 1 + $urandom_range(0, 1), $urandom_range(0, 2),
                  $urandom_range(0, 2), -1, 0, nw, fw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
